// File: rtl/if_fetch_unit_pkg.sv
// Shared constants, state encodings and types for the openmips instruction-fetch front end.
package if_fetch_unit_pkg;

  localparam logic RstEnable  = 1'b0;
  localparam logic RstDisable = 1'b1;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0] ZeroWord = '0;

  localparam logic [1:0] IF_IDLE  = 2'd0;
  localparam logic [1:0] IF_FETCH = 2'd1;
  localparam logic [1:0] IF_HOLD  = 2'd2;

  typedef struct packed {
    logic                   valid;
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } fetch_word_t;

  // Instruction addresses are always word aligned; low two bits are dropped.
  function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] addr);
    return {addr[InstAddrBus-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush/bubble clear it, load captures a word, otherwise it holds.
module if_id_reg
  import if_fetch_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   load,
  input  logic                   bubble,
  input  logic [InstAddrBus-1:0] in_pc,
  input  logic [InstBus-1:0]     in_inst,
  output logic [InstAddrBus-1:0] id_pc,
  output logic [InstBus-1:0]     id_inst,
  output logic                   id_valid
);

  fetch_word_t ifid_d, ifid_q;

  always_comb begin
    ifid_d = ifid_q;
    if (flush || bubble) begin
      ifid_d = '0;
    end else if (load) begin
      ifid_d.valid = 1'b1;
      ifid_d.pc    = in_pc;
      ifid_d.inst  = in_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) ifid_q <= '0;
    else                  ifid_q <= ifid_d;
  end

  assign id_pc    = ifid_q.pc;
  assign id_inst  = ifid_q.inst;
  assign id_valid = ifid_q.valid;

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch front end: owns the PC, runs the ROM request/ack handshake, buffers one word
// across decode stalls and applies delayed branches and flushes.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = 32'h0000_0000,
  parameter int                     PC_INC   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_id,
  input  logic                   branch_flag,
  input  logic [InstAddrBus-1:0] branch_target,
  input  logic                   flush,
  input  logic [InstAddrBus-1:0] flush_pc,
  output logic                   rom_ce,
  output logic [InstAddrBus-1:0] rom_addr,
  input  logic                   rom_ack,
  input  logic [InstBus-1:0]     rom_data,
  output logic [InstAddrBus-1:0] id_pc,
  output logic [InstBus-1:0]     id_inst,
  output logic                   id_valid
);

  logic [1:0]             state_d, state_q;
  logic [InstAddrBus-1:0] pc_d, pc_q;
  fetch_word_t            hold_d, hold_q;
  logic                   br_pend_d, br_pend_q;
  logic [InstAddrBus-1:0] br_tgt_d, br_tgt_q;

  logic                   ifid_load, ifid_bubble, ifid_flush;
  logic [InstAddrBus-1:0] ifid_pc;
  logic [InstBus-1:0]     ifid_inst;
  logic [InstAddrBus-1:0] next_pc;

  assign rom_ce   = (state_q == IF_FETCH);
  assign rom_addr = rom_ce ? pc_q : ZeroWord;

  // A branch seen this cycle supersedes any older pending target.
  assign next_pc = branch_flag ? word_align(branch_target) :
                   br_pend_q   ? word_align(br_tgt_q) :
                                 pc_q + InstAddrBus'(PC_INC);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_d      = hold_q;
    br_pend_d   = br_pend_q;
    br_tgt_d    = br_tgt_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_flush  = 1'b0;
    ifid_pc     = pc_q;
    ifid_inst   = rom_data;

    if (flush) begin
      ifid_flush = 1'b1;
      hold_d     = '0;
      br_pend_d  = 1'b0;
      pc_d       = word_align(flush_pc);
      state_d    = IF_IDLE;
    end else begin
      if (branch_flag) begin
        br_pend_d = 1'b1;
        br_tgt_d  = branch_target;
      end
      case (state_q)
        IF_IDLE: state_d = IF_FETCH;
        IF_FETCH: begin
          if (rom_ack) begin
            pc_d      = next_pc;
            br_pend_d = 1'b0;
            if (!stall_id) begin
              ifid_load = 1'b1;
            end else begin
              hold_d.valid = 1'b1;
              hold_d.pc    = pc_q;
              hold_d.inst  = rom_data;
              state_d      = IF_HOLD;
            end
          end else if (!stall_id) begin
            ifid_bubble = 1'b1;
          end
        end
        IF_HOLD: begin
          if (!stall_id) begin
            ifid_load   = hold_q.valid;
            ifid_bubble = !hold_q.valid;
            ifid_pc     = hold_q.pc;
            ifid_inst   = hold_q.inst;
            hold_d      = '0;
            state_d     = IF_FETCH;
          end
        end
        default: state_d = IF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q   <= IF_IDLE;
      pc_q      <= RESET_PC;
      hold_q    <= '0;
      br_pend_q <= 1'b0;
      br_tgt_q  <= ZeroWord;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      hold_q    <= hold_d;
      br_pend_q <= br_pend_d;
      br_tgt_q  <= br_tgt_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .flush    (ifid_flush),
    .load     (ifid_load),
    .bubble   (ifid_bubble),
    .in_pc    (ifid_pc),
    .in_inst  (ifid_inst),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .id_valid (id_valid)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized scoreboard bench for if_fetch_unit with a program-order reference model,
// plus a second instance started near the top of memory to exercise PC wraparound.
module tb_if_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_id = 1'b0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic        rom_ack = 1'b0;
  logic [31:0] rom_data = '0;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  logic        w_rom_ce;
  logic [31:0] w_rom_addr;
  logic [31:0] w_id_pc;
  logic [31:0] w_id_inst;
  logic        w_id_valid;
  logic [31:0] w_rom_data;

  int errors = 0;
  int checks = 0;

  exp_t        exp_q[$];
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_tgt;
  logic        last_flush;
  logic [31:0] w_exp;

  always #5 clk = ~clk;

  if_fetch_unit u_dut (
    .clk           (clk),
    .rst           (rst),
    .stall_id      (stall_id),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .rom_ce        (rom_ce),
    .rom_addr      (rom_addr),
    .rom_ack       (rom_ack),
    .rom_data      (rom_data),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .id_valid      (id_valid)
  );

  // Always-acknowledging ROM on a second instance that starts just below the wrap point.
  assign w_rom_data = w_rom_addr ^ 32'h5A5A_0000;

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .PC_INC(4)) u_wrap (
    .clk           (clk),
    .rst           (rst),
    .stall_id      (1'b0),
    .branch_flag   (1'b0),
    .branch_target (32'h0),
    .flush         (1'b0),
    .flush_pc      (32'h0),
    .rom_ce        (w_rom_ce),
    .rom_addr      (w_rom_addr),
    .rom_ack       (w_rom_ce),
    .rom_data      (w_rom_data),
    .id_pc         (w_id_pc),
    .id_inst       (w_id_inst),
    .id_valid      (w_id_valid)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h3401_1100;
    if (addr == 32'h4) return 32'h3402_0020;
    return {addr[15:0] ^ 16'hC3A5, addr[31:16] ^ 16'h0F0F};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Called at a negedge: drives the inputs for the next posedge, advances the
  // program-order model and returns at the following negedge.
  task automatic applyStimulus(input bit ack_i, input bit stall_i, input bit br_i,
                               input logic [31:0] tgt_i, input bit fl_i,
                               input logic [31:0] fpc_i);
    bit ce_now;
    ce_now = rom_ce;
    if (last_flush) checkOutput("idle_after_flush_ce", {31'b0, rom_ce}, 32'h0);
    if (ce_now) checkOutput("rom_addr", rom_addr, m_pc);
    rom_ack       = ack_i && ce_now;
    rom_data      = rom_word(rom_addr);
    stall_id      = stall_i;
    branch_flag   = br_i;
    branch_target = tgt_i;
    flush         = fl_i;
    flush_pc      = fpc_i;
    if (fl_i) begin
      exp_q.delete();
      m_pc   = {fpc_i[31:2], 2'b00};
      m_pend = 1'b0;
    end else begin
      if (br_i) begin
        m_pend = 1'b1;
        m_tgt  = tgt_i;
      end
      if (ack_i && ce_now) begin
        exp_q.push_back('{pc: m_pc, inst: rom_word(m_pc)});
        m_pc   = m_pend ? {m_tgt[31:2], 2'b00} : m_pc + 32'd4;
        m_pend = 1'b0;
      end
    end
    last_flush = fl_i;
    @(negedge clk);
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b0;
    rom_ack = 1'b0;
    stall_id = 1'b0;
    branch_flag = 1'b0;
    flush = 1'b0;
    repeat (cycles) @(negedge clk);
    exp_q.delete();
    m_pc = 32'h0;
    m_pend = 1'b0;
    last_flush = 1'b0;
    rst = 1'b1;
  endtask

  // Monitor: after every edge, decide what IF/ID must show and pop the scoreboard
  // whenever a new real instruction is presented.
  logic [31:0] prev_pc, prev_inst;
  logic        prev_valid;
  always @(posedge clk) begin
    logic s_rst, s_stall, s_flush;
    exp_t e;
    s_rst   = rst;
    s_stall = stall_id;
    s_flush = flush;
    #1;
    if (!s_rst) begin
      checkOutput("reset_id_valid", {31'b0, id_valid}, 32'h0);
      checkOutput("reset_id_inst", id_inst, 32'h0);
      checkOutput("reset_id_pc", id_pc, 32'h0);
      checkOutput("reset_rom_ce", {31'b0, rom_ce}, 32'h0);
      checkOutput("reset_rom_addr", rom_addr, 32'h0);
    end else if (s_flush) begin
      checkOutput("flush_id_valid", {31'b0, id_valid}, 32'h0);
      checkOutput("flush_id_inst", id_inst, 32'h0);
    end else if (s_stall) begin
      checkOutput("stall_hold_pc", id_pc, prev_pc);
      checkOutput("stall_hold_inst", id_inst, prev_inst);
      checkOutput("stall_hold_valid", {31'b0, id_valid}, {31'b0, prev_valid});
    end else if (id_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_inst_pc", id_pc, 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        checkOutput("id_pc", id_pc, e.pc);
        checkOutput("id_inst", id_inst, e.inst);
      end
    end else begin
      checkOutput("bubble_id_inst", id_inst, 32'h0);
    end
    prev_pc    = id_pc;
    prev_inst  = id_inst;
    prev_valid = id_valid;
  end

  always @(posedge clk) begin
    logic s_rst;
    s_rst = rst;
    #1;
    if (!s_rst) begin
      w_exp = 32'hFFFF_FFF8;
    end else if (w_id_valid) begin
      checkOutput("wrap_id_pc", w_id_pc, w_exp);
      checkOutput("wrap_id_inst", w_id_inst, w_exp ^ 32'h5A5A_0000);
      w_exp = w_exp + 32'd4;
    end
  end

  initial begin
    m_pc = 32'h0;
    m_pend = 1'b0;
    m_tgt = 32'h0;
    last_flush = 1'b0;
    @(negedge clk);
    doReset(3);

    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("post_reset_rom_ce", {31'b0, rom_ce}, 32'h1);
    checkOutput("post_reset_rom_addr", rom_addr, 32'h0);

    // Two-cycle ROM latency on the first two words.
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);

    // Stall spanning the ack at 0x8.
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("hold_rom_ce", {31'b0, rom_ce}, 32'h0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("hold_rom_ce_2", {31'b0, rom_ce}, 32'h0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("resume_rom_addr", rom_addr, 32'hC);
    applyStimulus(1, 0, 0, 0, 0, 0);

    // Branch with the delay-slot fetch at 0x10 in flight, then an unaligned target.
    applyStimulus(0, 0, 1, 32'h100, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h103, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);

    // Flush while holding a word under stall.
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 32'h200);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("flush_restart_addr", rom_addr, 32'h200);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(999) < 3) begin
        doReset(2);
      end else begin
        applyStimulus($urandom_range(99) < 50, $urandom_range(99) < 25,
                      $urandom_range(99) < 8, $urandom(),
                      $urandom_range(99) < 3, $urandom());
      end
    end

    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("scoreboard_drained", exp_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
